// File: rtl/if_stage.sv
// if_stage: RISC-V fetch stage owning the PC, imem request/ready handshake and IF/ID register.
// Define IF_PERF_CNT_EN to add perf_fetched / perf_stall_cycles counters.
module if_stage #(
    parameter int PC_W = 9,
    parameter int INS_W = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter logic [INS_W-1:0] NOP = 32'h00000013
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_target,
    output logic             imem_req,
    output logic [PC_W-1:0]  imem_addr,
    input  logic             imem_ready,
    input  logic [INS_W-1:0] imem_rdata,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]      perf_fetched,
    output logic [31:0]      perf_stall_cycles,
`endif
    output logic             if_id_valid,
    output logic [PC_W-1:0]  if_id_pc,
    output logic [INS_W-1:0] if_id_instr,
    output logic [6:0]       opcode
);
    typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d, addr_q, addr_d, ipc_q, ipc_d;
    logic [INS_W-1:0]  skid_q, skid_d, ins_q, ins_d;
    logic              req_q, req_d, v_q, v_d, rdy, load;

    always_comb begin
        rdy = imem_ready & req_q;
        state_d = state_q;
        pc_d = pc_q;
        skid_d = skid_q;
        v_d = v_q;
        ipc_d = ipc_q;
        ins_d = ins_q;
        load = 1'b0;
        if (branch_taken) begin
            // A request still in flight must complete at its old address before refetching
            state_d = (state_q != HOLD && req_q && !rdy) ? DRAIN : FETCH;
            pc_d = branch_target & ~PC_W'(3);
            v_d = 1'b0;
            ipc_d = '0;
            ins_d = NOP;
        end else if (state_q == FETCH) begin
            if (rdy && !stall) begin
                load = 1'b1;
                ins_d = imem_rdata;
            end else if (rdy) begin
                skid_d = imem_rdata;
                state_d = HOLD;
            end else if (!stall) begin
                v_d = 1'b0;
                ipc_d = pc_q;
                ins_d = NOP;
            end
        end else if (state_q == HOLD) begin
            if (!stall) begin
                load = 1'b1;
                ins_d = skid_q;
                state_d = FETCH;
            end
        end else if (rdy) begin
            state_d = FETCH;
        end
        if (load) begin
            v_d = 1'b1;
            ipc_d = pc_q;
            pc_d = pc_q + PC_W'(4);
        end
        req_d = state_d != HOLD;
        addr_d = (state_q == DRAIN) ? addr_q : pc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q <= RESET_PC;
            addr_q <= RESET_PC;
            skid_q <= NOP;
            req_q <= 1'b0;
            v_q <= 1'b0;
            ipc_q <= '0;
            ins_q <= NOP;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            addr_q <= addr_d;
            skid_q <= skid_d;
            req_q <= req_d;
            v_q <= v_d;
            ipc_q <= ipc_d;
            ins_q <= ins_d;
        end
    end

    assign imem_req = req_q;
    assign imem_addr = (state_q == DRAIN) ? addr_q : pc_q;
    assign if_id_valid = v_q;
    assign if_id_pc = ipc_q;
    assign if_id_instr = ins_q;
    assign opcode = ins_q[6:0];

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetched_q, stalls_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fetched_q <= '0;
            stalls_q <= '0;
        end else begin
            fetched_q <= fetched_q + 32'(load);
            stalls_q <= stalls_q + 32'(stall);
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_stall_cycles = stalls_q;
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: directed and randomized checks of if_stage against a fetch-stream scoreboard.
module tb_if_stage;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0, reset = 1'b1, stall = 1'b0, branch_taken = 1'b0;
    logic [8:0]  branch_target = '0;
    logic        imem_req, imem_ready = 1'b0;
    logic [8:0]  imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        if_id_valid;
    logic [8:0]  if_id_pc;
    logic [31:0] if_id_instr;
    logic [6:0]  opcode;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall_cycles;
`endif

    if_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
`ifdef IF_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_stall_cycles(perf_stall_cycles),
`endif
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_instr(if_id_instr),
        .opcode(opcode)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    int nloads = 0, total_loads = 0, stalls = 0, wcnt = 0, lat = 0, lat_lo = 0, lat_hi = 0;
    logic [8:0]  exp_pc = '0, p_tgt, p_addr, p_pc;
    logic [31:0] p_ins;
    bit drain = 0, p_reset, p_stall, p_br, p_req, p_rdy, p_drain, p_v, loaded;

    function automatic logic [31:0] word(input logic [8:0] a);
        return {16'hA5C3, a, a[6:0] ^ 7'h2A};
    endfunction

    function automatic logic [63:0] mk(input logic v, input logic [8:0] pc, input logic [31:0] ins);
        return {22'b0, v, pc, ins};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        imem_ready = imem_req && wcnt >= lat;
        imem_rdata = imem_ready ? word(imem_addr) : $urandom;
        p_reset = reset; p_stall = stall; p_br = branch_taken; p_tgt = branch_target;
        p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
        p_v = if_id_valid; p_pc = if_id_pc; p_ins = if_id_instr; p_drain = drain;
        @(posedge clk);
        #1;
        if (p_rdy) begin
            wcnt = 0;
            lat = $urandom_range(lat_hi, lat_lo);
        end else if (p_req) wcnt++;
        chk("opcode", opcode, if_id_instr[6:0]);
        if (p_reset) begin
            chk("rst_req", imem_req, 0);
            chk("rst_addr", imem_addr, 0);
            chk("rst_ifid", mk(if_id_valid, if_id_pc, if_id_instr), mk(0, 0, NOP));
            chk("rst_opcode", opcode, 7'b0010011);
            exp_pc = '0; drain = 0; wcnt = 0; lat = lat_hi; nloads = 0; stalls = 0;
        end else begin
            loaded = if_id_valid && !(p_v && if_id_pc == p_pc);
            if (p_stall) stalls++;
            if (p_br) begin
                chk("flush", mk(if_id_valid, if_id_pc, if_id_instr), mk(0, 0, NOP));
                exp_pc = {p_tgt[8:2], 2'b00};
                drain = p_req && !p_rdy;
            end else begin
                if (p_drain) chk("drain_bubble", mk(if_id_valid, if_id_pc, if_id_instr), mk(0, 0, NOP));
                else if (p_stall) chk("stall_hold", mk(if_id_valid, if_id_pc, if_id_instr), mk(p_v, p_pc, p_ins));
                else if (p_req && !p_rdy) chk("wait_bubble", mk(if_id_valid, if_id_pc, if_id_instr), mk(0, p_addr, NOP));
                if (p_rdy && p_stall && !p_drain) chk("hold_req", imem_req, 0);
                if (p_rdy) drain = 0;
            end
            if (loaded) begin
                chk("pc_seq", if_id_pc, exp_pc);
                chk("instr", if_id_instr, word(if_id_pc));
                exp_pc = exp_pc + 9'd4;
                nloads++;
                total_loads++;
            end
            if (p_req && !p_rdy && imem_req) chk("addr_stable", imem_addr, p_addr);
            if (!p_req && (!p_stall || p_br)) chk("req_rise", imem_req, 1);
        end
    endtask

    task automatic do_reset(input int lo, input int hi);
        lat_lo = lo; lat_hi = hi;
        reset = 1; stall = 0; branch_taken = 0;
        step();
        step();
        reset = 0;
    endtask

    initial begin
        do_reset(0, 0);
        step();
        chk("first_req", imem_req, 1);
        chk("first_valid", if_id_valid, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("zw_pc", if_id_pc, 9'(k * 4));
            chk("zw_valid", if_id_valid, 1);
        end

        do_reset(3, 3);
        for (int k = 0; k < 17; k++) step();
        chk("lat3_loads", nloads, 4);
        chk("lat3_addr", imem_addr, 9'h10);
        branch_taken = 1; branch_target = 9'h40;
        step();
        branch_taken = 0;
        chk("drain_addr", {imem_req, imem_addr}, {1'b1, 9'h10});
        for (int k = 0; k < 30 && !if_id_valid; k++) step();
        chk("redirect_valid", if_id_valid, 1);
        chk("redirect_pc", if_id_pc, 9'h40);

        do_reset(0, 0);
        for (int k = 0; k < 3; k++) step();
        chk("addr8", imem_addr, 9'h8);
        stall = 1;
        step();
        chk("hold_req0", imem_req, 0);
        chk("hold_frozen", if_id_pc, 9'h4);
        for (int k = 0; k < 4; k++) step();
        stall = 0;
        step();
        chk("release_ifid", mk(if_id_valid, if_id_pc, if_id_instr), mk(1, 9'h8, word(9'h8)));
        chk("next_req", {imem_req, imem_addr}, {1'b1, 9'hC});

        do_reset(0, 0);
        for (int k = 0; k < 3; k++) step();
        stall = 1; branch_taken = 1; branch_target = 9'h83;
        step();
        stall = 0; branch_taken = 0;
        chk("tgt_align", imem_addr, 9'h80);
        branch_taken = 1; branch_target = 9'h1F8;
        step();
        branch_taken = 0;
        for (int k = 0; k < 10 && !(if_id_valid && if_id_pc == 9'h1FC); k++) step();
        chk("at_1fc", if_id_pc, 9'h1FC);
        step();
        chk("wrap_pc", mk(if_id_valid, if_id_pc, 32'h0), mk(1, 9'h0, 32'h0));

        do_reset(0, 0);
        for (int k = 0; k < 3; k++) step();
        stall = 1;
        step();
        chk("hold_entered", imem_req, 0);
        reset = 1;
        step();
        reset = 0; stall = 0;
        step();
        chk("restart", {imem_req, imem_addr}, {1'b1, 9'h0});

        do_reset(0, 3);
        for (int k = 0; k < 3000; k++) begin
            stall = $urandom_range(4, 0) == 0;
            branch_taken = $urandom_range(9, 0) == 0;
            branch_target = 9'($urandom);
            reset = $urandom_range(499, 0) == 0;
            step();
        end
        reset = 0; stall = 0; branch_taken = 0;
        step();
        chk("progress", total_loads > 300, 1);
`ifdef IF_PERF_CNT_EN
        chk("perf_fetched", perf_fetched, nloads);
        chk("perf_stalls", perf_stall_cycles, stalls);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
